// File: rtl/line_cmd_queue.sv
// MMIO command queue feeding the line engine: staging registers, a DEPTH-entry
// command FIFO and a strobe sequencer. Define LQ_COLOR_SKIP_EN to skip repeated colors.
module line_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_we,
  input  logic [2:0]       cmd_addr,
  input  logic [31:0]      cmd_data,
  output logic [PTR_W:0]   lq_count,
  output logic             lq_full,
  output logic             lq_busy,
  output logic             lq_overflow,
  input  logic             LE_ready,
  output logic [31:0]      LE_color,
  output logic [9:0]       LE_point,
  output logic             LE_color_valid,
  output logic             LE_x0_valid,
  output logic             LE_y0_valid,
  output logic             LE_x1_valid,
  output logic             LE_y1_valid,
  output logic             LE_trigger
);

  typedef struct packed {
    logic [31:0] color;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE, S_COL, S_X0, S_Y0, S_X1, S_Y1, TRIG, SETTLE, WAIT
  } state_t;

  state_t            state_q, state_d;
  cmd_t              stage_q;
  cmd_t              hold_q;
  cmd_t              mem_q [DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              overflow_q;
  logic              goWr, clrWr, fifoEmpty, fifoFull, push, pop, skipColor;

  assign goWr      = cmd_we && (cmd_addr == 3'd5);
  assign clrWr     = cmd_we && (cmd_addr == 3'd6);
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == (PTR_W+1)'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign pop       = (state_q == IDLE) && !fifoEmpty && LE_ready;
  // A GO into a full queue still lands if the sequencer frees a slot on the same edge.
  assign push      = goWr && (!fifoFull || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else if (cmd_we) begin
      case (cmd_addr)
        3'd0:    stage_q.color <= cmd_data;
        3'd1:    stage_q.x0    <= cmd_data[9:0];
        3'd2:    stage_q.y0    <= cmd_data[9:0];
        3'd3:    stage_q.x1    <= cmd_data[9:0];
        3'd4:    stage_q.y1    <= cmd_data[9:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= stage_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        hold_q   <= head;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
      if (goWr && fifoFull && !pop) begin
        overflow_q <= 1'b1;
      end else if (clrWr) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef LQ_COLOR_SKIP_EN
  logic [31:0] last_color_q;
  logic        color_sent_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_color_q <= '0;
      color_sent_q <= 1'b0;
    end else if (state_q == S_COL) begin
      last_color_q <= hold_q.color;
      color_sent_q <= 1'b1;
    end
  end

  assign skipColor = color_sent_q && (head.color == last_color_q);
`else
  assign skipColor = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output strobes depend only on state_q and hold_q, never on live inputs.
  always_comb begin
    state_d        = state_q;
    LE_point       = '0;
    LE_color_valid = 1'b0;
    LE_x0_valid    = 1'b0;
    LE_y0_valid    = 1'b0;
    LE_x1_valid    = 1'b0;
    LE_y1_valid    = 1'b0;
    LE_trigger     = 1'b0;
    case (state_q)
      IDLE:   if (pop) state_d = skipColor ? S_X0 : S_COL;
      S_COL: begin
        LE_color_valid = 1'b1;
        state_d        = S_X0;
      end
      S_X0: begin
        LE_point    = hold_q.x0;
        LE_x0_valid = 1'b1;
        state_d     = S_Y0;
      end
      S_Y0: begin
        LE_point    = hold_q.y0;
        LE_y0_valid = 1'b1;
        state_d     = S_X1;
      end
      S_X1: begin
        LE_point    = hold_q.x1;
        LE_x1_valid = 1'b1;
        state_d     = S_Y1;
      end
      S_Y1: begin
        LE_point    = hold_q.y1;
        LE_y1_valid = 1'b1;
        state_d     = TRIG;
      end
      TRIG: begin
        LE_trigger = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: state_d = WAIT;
      WAIT:   if (LE_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign LE_color    = hold_q.color;
  assign lq_count    = count_q;
  assign lq_full     = fifoFull;
  assign lq_busy     = !fifoEmpty || (state_q != IDLE);
  assign lq_overflow = overflow_q;

endmodule

// File: tb/tb_line_cmd_queue.sv
// Scoreboard bench for line_cmd_queue: expected lines are queued at GO time and a
// negedge monitor rebuilds each replay from the engine strobes and compares in order.
module tb_line_cmd_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef LQ_COLOR_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] color;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_we;
  logic [2:0]       cmd_addr;
  logic [31:0]      cmd_data;
  logic [PTR_W:0]   lq_count;
  logic             lq_full, lq_busy, lq_overflow;
  logic             LE_ready;
  logic [31:0]      LE_color;
  logic [9:0]       LE_point;
  logic             LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
  logic             LE_trigger;

  line_cmd_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .lq_count(lq_count), .lq_full(lq_full), .lq_busy(lq_busy), .lq_overflow(lq_overflow),
    .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
    .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
    .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lastWrEdge = 0;
  cmd_t expQ[$];
  cmd_t stage;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: leaves idle when it sees a trigger and stays busy busyLen cycles.
  int busyLen = 3;
  int busyCnt = 0;
  bit holdOff = 1'b0;
  initial begin
    LE_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (LE_trigger) busyCnt = busyLen;
      else if (busyCnt > 0) busyCnt--;
      LE_ready = !holdOff && (busyCnt == 0);
    end
  end

  logic readyAtEdge = 1'b0;
  always @(posedge clk) readyAtEdge <= LE_ready;

  // Monitor: rebuilds each replay and checks it against the scoreboard head.
  bit          inSeq = 1'b0;
  bit          gotColor = 1'b0;
  bit          monHave = 1'b0;
  logic [31:0] monLast = '0;
  int          prevIdx = 0;
  int          monIdx = 0;
  int          trigCount = 0;
  int          strobeTotal = 0;
  int          lastColorEdge = 0;
  int          lastTrigEdge = 0;
  logic [5:0]  monS;
  cmd_t        cap = '0;
  cmd_t        expCmd;

  always @(negedge clk) begin
    if (!rst) begin
      inSeq    = 1'b0;
      gotColor = 1'b0;
      monHave  = 1'b0;
      cap      = '0;
    end else begin
      monS = {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger};
      if (monS != 6'b0) begin
        strobeTotal++;
        checkOutput("oneStrobe", 72'($onehot(monS)), 72'd1);
        if (monS[5]) monIdx = 0;
        else if (monS[4]) monIdx = 1;
        else if (monS[3]) monIdx = 2;
        else if (monS[2]) monIdx = 3;
        else if (monS[1]) monIdx = 4;
        else monIdx = 5;
        if (!inSeq) begin
          checkOutput("seqStart", 72'(monIdx == 0 || (SKIP_EN && monIdx == 1)), 72'd1);
          checkOutput("readyAtPop", 72'(readyAtEdge), 72'd1);
          inSeq    = 1'b1;
          gotColor = 1'b0;
        end else begin
          checkOutput("strobeOrder", 72'(monIdx), 72'(prevIdx + 1));
        end
        prevIdx = monIdx;
        case (monIdx)
          0: begin
            gotColor      = 1'b1;
            lastColorEdge = cyc + 1;
            checkOutput("pointIdleOnColor", 72'(LE_point), 72'd0);
          end
          1: cap.x0 = LE_point;
          2: cap.y0 = LE_point;
          3: cap.x1 = LE_point;
          4: cap.y1 = LE_point;
          default: begin
            inSeq        = 1'b0;
            trigCount++;
            lastTrigEdge = cyc + 1;
            cap.color    = LE_color;
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpectedTrig: got trigger with line 0x%0h expected none", cap);
            end else begin
              expCmd = expQ.pop_front();
              checkOutput("replay", cap, expCmd);
              checkOutput("colorStrobe", 72'(gotColor),
                          72'(!(SKIP_EN && monHave && expCmd.color == monLast)));
              monHave = 1'b1;
              monLast = expCmd.color;
            end
          end
        endcase
      end
    end
  end

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    cmd_we   = 1'b1;
    cmd_addr = a;
    cmd_data = d;
    @(posedge clk);
    #1;
    lastWrEdge = cyc;
    cmd_we   = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
  endtask

  // Updates the staging model; a GO enqueues the expected line when accepted.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d, input bit accept);
    case (a)
      3'd0: stage.color = d;
      3'd1: stage.x0 = d[9:0];
      3'd2: stage.y0 = d[9:0];
      3'd3: stage.x1 = d[9:0];
      3'd4: stage.y1 = d[9:0];
      3'd5: if (accept) expQ.push_back(stage);
      default: ;
    endcase
    writeReg(a, d);
  endtask

  task automatic sendLine(input logic [31:0] c, input int x0, input int y0, input int x1,
                          input int y1, input bit accept);
    applyStimulus(3'd0, c, 1'b0);
    applyStimulus(3'd1, 32'(x0), 1'b0);
    applyStimulus(3'd2, 32'(y0), 1'b0);
    applyStimulus(3'd3, 32'(x1), 1'b0);
    applyStimulus(3'd4, 32'(y1), 1'b0);
    applyStimulus(3'd5, 32'h0, accept);
  endtask

  task automatic waitTrig(input int bound, input string name);
    int start;
    int n;
    start = trigCount;
    n = 0;
    while (trigCount == start && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 72'(trigCount == start), 72'd0);
  endtask

  task automatic waitIdle(input int bound, input string name);
    int n;
    n = 0;
    while ((lq_busy || expQ.size() != 0) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 72'(lq_busy || expQ.size() != 0), 72'd0);
  endtask

  function automatic logic [71:0] allOutputs();
    return 72'({LE_color, LE_point, LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid,
                LE_y1_valid, LE_trigger, lq_count, lq_full, lq_busy, lq_overflow});
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] colors [3];
  int          g, lat, saved, r, n;
  bit          skHave;
  logic [31:0] skLast;

  initial begin
    rst      = 1'b0;
    cmd_we   = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    stage    = '0;
    colors[0] = 32'h00FF0000;
    colors[1] = 32'h0000FF00;
    colors[2] = 32'h000000FF;
    #12;
    checkOutput("resetOutputs", allOutputs(), 72'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single line");
    busyLen = 30;
    sendLine(32'h00FF0000, 10, 20, 100, 50, 1'b1);
    g = lastWrEdge;
    waitTrig(20, "singleTrigTimeout");
    checkOutput("latColor", 72'(lastColorEdge), 72'(g + 2));
    checkOutput("latTrig", 72'(lastTrigEdge), 72'(g + 7));
    repeat (15) @(posedge clk);
    #1;
    checkOutput("busyWhileEngineBusy", 72'(lq_busy), 72'd1);
    waitIdle(60, "singleDrain");

    $display("[TB] back-to-back");
    busyLen = 4;
    holdOff = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) sendLine(32'h00123456, 5, 6, 200 + i, 7, 1'b1);
    checkOutput("count3", 72'(lq_count), 72'd3);
    holdOff = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitTrig(40, "b2bTrigTimeout");
      checkOutput("countAfterPop", 72'(lq_count), 72'(2 - i));
    end
    waitIdle(60, "b2bDrain");

    $display("[TB] overflow and collision");
    holdOff = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) sendLine(32'hA0000000 + 32'(i), 300 + i, 11, 12, 13, i < 4);
    checkOutput("ovfCount", 72'(lq_count), 72'd4);
    checkOutput("ovfFull", 72'(lq_full), 72'd1);
    checkOutput("ovfSticky", 72'(lq_overflow), 72'd1);
    applyStimulus(3'd6, 32'h0, 1'b0);
    checkOutput("ovfCleared", 72'(lq_overflow), 72'd0);
    applyStimulus(3'd0, 32'hC0111DE0, 1'b0);
    applyStimulus(3'd1, 32'hFFFFF3FF, 1'b0);
    applyStimulus(3'd2, 32'd444, 1'b0);
    applyStimulus(3'd3, 32'd555, 1'b0);
    applyStimulus(3'd4, 32'd666, 1'b0);
    holdOff = 1'b0;
    @(negedge clk);
    #1;
    applyStimulus(3'd5, 32'h0, 1'b1);
    checkOutput("collisionCount", 72'(lq_count), 72'd4);
    checkOutput("collisionNoOvf", 72'(lq_overflow), 72'd0);
    waitIdle(300, "collisionDrain");

    $display("[TB] reset mid-sequence");
    busyLen = 2;
    sendLine(32'h0BADF00D, 1, 2, 3, 4, 1'b1);
    sendLine(32'h0BADF00D, 5, 6, 7, 8, 1'b1);
    n = 0;
    while (!LE_x1_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachX1", 72'(LE_x1_valid), 72'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("resetMidOutputs", allOutputs(), 72'd0);
    expQ.delete();
    stage = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saved = strobeTotal;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("noStrobesAfterReset", 72'(strobeTotal), 72'(saved));
    checkOutput("idleAfterReset", 72'(lq_busy), 72'd0);

    $display("[TB] color reuse");
    skHave = 1'b0;
    skLast = '0;
    for (int i = 0; i < 3; i++) begin
      sendLine((i < 2) ? 32'h00ABCDEF : 32'h00FEDCBA, 40 + i, 41, 42, 43, 1'b1);
      g = lastWrEdge;
      waitTrig(20, "skipTrigTimeout");
      lat = lastTrigEdge - g;
      checkOutput("skipLatency", 72'(lat),
                  72'((SKIP_EN && skHave && skLast == ((i < 2) ? 32'h00ABCDEF : 32'h00FEDCBA)) ? 6 : 7));
      skHave = 1'b1;
      skLast = (i < 2) ? 32'h00ABCDEF : 32'h00FEDCBA;
      waitIdle(40, "skipDrain");
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if (r == 0) applyStimulus(3'd0, colors[$urandom_range(0, 2)], 1'b0);
        else applyStimulus(3'(r), $urandom, 1'b0);
      end else if (r <= 6) begin
        if (expQ.size() < DEPTH) applyStimulus(3'd5, $urandom, 1'b1);
        else begin
          @(posedge clk);
          #1;
        end
      end else if (r == 7) begin
        applyStimulus(($urandom_range(0, 1) == 1) ? 3'd6 : 3'd7, $urandom, 1'b0);
      end else if (r == 8) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end else begin
        holdOff = ($urandom_range(0, 3) == 0);
        busyLen = $urandom_range(0, 6);
        @(posedge clk);
        #1;
      end
    end
    holdOff = 1'b0;
    waitIdle(2000, "randomDrain");
    checkOutput("randomNoOvf", 72'(lq_overflow), 72'd0);
    checkOutput("randomCountZero", 72'(lq_count), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
